// File: rtl/trigger_initiator_if.sv
// Control and responder signals of one trigger/active/done initiator.
// master is the initiator's view; slave is the sequencer/responder side.
interface trigger_initiator_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_jobs;
    logic             abort;
    logic             active_in;
    logic             done_in;
    logic             trigger;
    logic             busy;
    logic [CNT_W-1:0] jobs_done;
    logic             error;
    logic             finished;

    modport master (
        input  start, num_jobs, abort, active_in, done_in,
        output trigger, busy, jobs_done, error, finished
    );

    modport slave (
        output start, num_jobs, abort, active_in, done_in,
        input  trigger, busy, jobs_done, error, finished
    );
endinterface

// File: rtl/trigger_initiator.sv
// Batch initiator for the trigger/active/done protocol: pulses trigger,
// waits for active then done, inserts a gap, repeats num_jobs times.
module trigger_initiator #(
    parameter int PULSE_WIDTH = 1,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 15,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    trigger_initiator_if.master bus
);
    localparam int SEQ_MAX = (PULSE_WIDTH > GAP_CYCLES) ? PULSE_WIDTH : GAP_CYCLES;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam int TMR_W   = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_ACTIVE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t           state;
    logic [SEQ_W-1:0] seq_cnt;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] jobs_next;
    logic             timer_last;

    assign jobs_next  = bus.jobs_done + 1'b1;
    assign timer_last = (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            seq_cnt       <= '0;
            timer         <= '0;
            target        <= '0;
            bus.trigger   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.jobs_done <= '0;
            bus.error     <= 1'b0;
            bus.finished  <= 1'b0;
        end else begin
            bus.finished <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    bus.jobs_done <= '0;
                    bus.error     <= 1'b0;
                    if (bus.num_jobs != '0) begin
                        target      <= bus.num_jobs;
                        seq_cnt     <= '0;
                        state       <= PULSE;
                        bus.trigger <= 1'b1;
                        bus.busy    <= 1'b1;
                    end else begin
                        bus.finished <= 1'b1;
                    end
                end
            end else if (bus.abort) begin
                // abort beats a same-cycle done or timeout; the job is not counted
                state        <= IDLE;
                bus.trigger  <= 1'b0;
                bus.busy     <= 1'b0;
                bus.finished <= 1'b1;
            end else begin
                case (state)
                    PULSE: begin
                        if (seq_cnt == SEQ_W'(PULSE_WIDTH - 1)) begin
                            state       <= WAIT_ACTIVE;
                            timer       <= '0;
                            bus.trigger <= 1'b0;
                        end else begin
                            seq_cnt <= seq_cnt + 1'b1;
                        end
                    end
                    WAIT_ACTIVE, WAIT_DONE: begin
                        // done is accepted in WAIT_ACTIVE too (responder skipped active)
                        if (bus.done_in) begin
                            bus.jobs_done <= jobs_next;
                            if (jobs_next == target) begin
                                state        <= IDLE;
                                bus.busy     <= 1'b0;
                                bus.finished <= 1'b1;
                            end else begin
                                state   <= GAP;
                                seq_cnt <= '0;
                            end
                        end else if (state == WAIT_ACTIVE && bus.active_in) begin
                            state <= WAIT_DONE;
                            timer <= '0;
                        end else if (timer_last) begin
                            state        <= IDLE;
                            bus.busy     <= 1'b0;
                            bus.error    <= 1'b1;
                            bus.finished <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    GAP: begin
                        if (seq_cnt == SEQ_W'(GAP_CYCLES - 1)) begin
                            state       <= PULSE;
                            seq_cnt     <= '0;
                            bus.trigger <= 1'b1;
                        end else begin
                            seq_cnt <= seq_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        bus.trigger <= 1'b0;
                        bus.busy    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trigger_initiator.sv
// Directed bench: two initiators (default timing and PW=3/GAP=4) driven by a
// small responder model with hand-computed expectations.
module tb_trigger_initiator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       st[2], ab[2], act[2], dn[2];
    logic [7:0] nj[2];
    logic       trg[2], bsy[2], err[2], fin[2];
    logic [7:0] jd[2];

    trigger_initiator_if #(.CNT_W(8)) b0 ();
    trigger_initiator_if #(.CNT_W(8)) b1 ();

    assign b0.start = st[0];  assign b0.num_jobs = nj[0];  assign b0.abort = ab[0];
    assign b0.active_in = act[0];  assign b0.done_in = dn[0];
    assign b1.start = st[1];  assign b1.num_jobs = nj[1];  assign b1.abort = ab[1];
    assign b1.active_in = act[1];  assign b1.done_in = dn[1];
    assign trg[0] = b0.trigger;  assign bsy[0] = b0.busy;  assign jd[0] = b0.jobs_done;
    assign err[0] = b0.error;    assign fin[0] = b0.finished;
    assign trg[1] = b1.trigger;  assign bsy[1] = b1.busy;  assign jd[1] = b1.jobs_done;
    assign err[1] = b1.error;    assign fin[1] = b1.finished;

    trigger_initiator u_dut0 (.clk(clk), .reset(rst), .bus(b0.master));
    trigger_initiator #(.PULSE_WIDTH(3), .GAP_CYCLES(4)) u_dut1 (.clk(clk), .reset(rst), .bus(b1.master));

    int   n_chk = 0;
    int   n_err = 0;
    int   rc[2];
    logic rprev[2];
    bit   en[2];
    int   dcnt[2];
    int   rises, hi_min, hi_max, gap_min, gap_max, fin_n, lowbusy, seqerr;
    logic e1, t1trg, f1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Responder: active from one cycle after the trigger rise for 5 cycles, then a 1-cycle done.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!en[d]) rc[d] = 0;
            else if (trg[d] && !rprev[d] && rc[d] == 0) rc[d] = 1;
            else if (rc[d] == 7) rc[d] = 0;
            else if (rc[d] > 0) rc[d]++;
            rprev[d] = trg[d];
            act[d] = (rc[d] >= 2 && rc[d] <= 6);
            dn[d]  = (rc[d] == 7);
            if (dn[d]) dcnt[d]++;
        end
    endtask

    task automatic run(input int d, input int n, input bit poke, input bit abt, input int budget);
        int   t, tail, hi, done_t, pjd;
        logic pt;
        rises = 0; hi_min = 999; hi_max = 0; gap_min = 999; gap_max = 0;
        fin_n = 0; lowbusy = 0; seqerr = 0;
        hi = 0; done_t = -1; tail = -1; t = 0; pjd = 0;
        pt = trg[d]; dcnt[d] = 0;
        st[d] = 1'b1; nj[d] = 8'(n); ab[d] = abt;
        while (tail != 0 && t < budget) begin
            tick();
            t++;
            if (t == 1) begin
                st[d] = 1'b0; ab[d] = 1'b0;
                e1 = err[d]; t1trg = trg[d]; f1 = fin[d]; pjd = int'(jd[d]);
            end else begin
                st[d] = poke && dn[d] && dcnt[d] == 1;
            end
            if (trg[d] && !pt) begin
                rises++;
                hi = 1;
                if (done_t >= 0) begin
                    if (t - done_t - 1 < gap_min) gap_min = t - done_t - 1;
                    if (t - done_t - 1 > gap_max) gap_max = t - done_t - 1;
                end
            end else if (trg[d]) begin
                hi++;
            end else if (pt) begin
                if (hi < hi_min) hi_min = hi;
                if (hi > hi_max) hi_max = hi;
            end
            if (bsy[d] && !trg[d]) lowbusy++;
            if (int'(jd[d]) != pjd) begin
                if (int'(jd[d]) != pjd + 1) seqerr++;
                pjd = int'(jd[d]);
            end
            if (fin[d]) begin
                fin_n++;
                if (tail < 0) tail = 4;
            end
            if (dn[d]) done_t = t;
            if (tail > 0) tail--;
            pt = trg[d];
        end
        chk("batch_end", 32'(tail == 0), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        for (int d = 0; d < 2; d++) begin
            st[d] = 0; ab[d] = 0; act[d] = 0; dn[d] = 0; nj[d] = 0;
            en[d] = 1; rc[d] = 0; rprev[d] = 0; dcnt[d] = 0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_trigger", 32'(trg[d]), 0);
            chk("rst_busy", 32'(bsy[d]), 0);
            chk("rst_jobs", 32'(jd[d]), 0);
            chk("rst_error", 32'(err[d]), 0);
            chk("rst_finished", 32'(fin[d]), 0);
        end
        rst = 1'b0;
        tick();

        // reset in WAIT_DONE of the second job
        st[0] = 1; nj[0] = 3;
        tick();
        st[0] = 0;
        k = 0;
        while (!(jd[0] == 1 && rc[0] == 4) && k < 100) begin tick(); k++; end
        chk("mid_reach_wait_done", 32'(k < 100), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_trigger", 32'(trg[0]), 0);
        chk("mid_rst_busy", 32'(bsy[0]), 0);
        chk("mid_rst_jobs", 32'(jd[0]), 0);
        chk("mid_rst_error", 32'(err[0]), 0);
        chk("mid_rst_finished", 32'(fin[0]), 0);
        for (int i = 0; i < 8; i++) tick();

        // loopback, 3 jobs
        run(0, 3, 0, 0, 200);
        chk("lb_trig_after_start", 32'(t1trg), 1);
        chk("lb_rises", 32'(rises), 3);
        chk("lb_hi_min", 32'(hi_min), 1);
        chk("lb_hi_max", 32'(hi_max), 1);
        chk("lb_gap_min", 32'(gap_min), 2);
        chk("lb_gap_max", 32'(gap_max), 2);
        chk("lb_jobs_seq", 32'(seqerr), 0);
        chk("lb_jobs", 32'(jd[0]), 3);
        chk("lb_finished_n", 32'(fin_n), 1);
        chk("lb_error", 32'(err[0]), 0);
        chk("lb_busy_after", 32'(bsy[0]), 0);

        // abort together with the second done
        dcnt[0] = 0;
        st[0] = 1; nj[0] = 4;
        tick();
        st[0] = 0;
        k = 0;
        while (!(dn[0] && dcnt[0] == 2) && k < 100) begin tick(); k++; end
        chk("ab_reach_done2", 32'(k < 100), 1);
        ab[0] = 1;
        tick();
        ab[0] = 0;
        chk("ab_jobs", 32'(jd[0]), 1);
        chk("ab_finished", 32'(fin[0]), 1);
        chk("ab_trigger", 32'(trg[0]), 0);
        chk("ab_busy", 32'(bsy[0]), 0);
        chk("ab_error", 32'(err[0]), 0);
        tick();
        chk("ab_finished_1cyc", 32'(fin[0]), 0);

        // zero-length batch
        run(0, 0, 0, 0, 20);
        chk("z_finished_next", 32'(f1), 1);
        chk("z_finished_n", 32'(fin_n), 1);
        chk("z_rises", 32'(rises), 0);
        chk("z_busy_cycles", 32'(lowbusy), 0);
        chk("z_jobs", 32'(jd[0]), 0);

        // abort in IDLE does nothing
        ab[0] = 1;
        tick();
        ab[0] = 0;
        chk("idle_abort_busy", 32'(bsy[0]), 0);
        chk("idle_abort_fin", 32'(fin[0]), 0);

        // mute responder; start and abort together in IDLE
        en[0] = 0;
        run(0, 2, 0, 1, 60);
        chk("mute_start_wins", 32'(t1trg), 1);
        chk("mute_wait_cycles", 32'(lowbusy), 15);
        chk("mute_error", 32'(err[0]), 1);
        chk("mute_finished_n", 32'(fin_n), 1);
        chk("mute_jobs", 32'(jd[0]), 0);
        chk("mute_rises", 32'(rises), 1);
        en[0] = 1;
        run(0, 1, 0, 0, 60);
        chk("clr_error_on_start", 32'(e1), 0);
        chk("clr_jobs", 32'(jd[0]), 1);
        chk("clr_error_end", 32'(err[0]), 0);

        // wide pulse / long gap, start poked mid-batch
        run(1, 2, 1, 0, 200);
        chk("w_rises", 32'(rises), 2);
        chk("w_hi_min", 32'(hi_min), 3);
        chk("w_hi_max", 32'(hi_max), 3);
        chk("w_gap_min", 32'(gap_min), 4);
        chk("w_gap_max", 32'(gap_max), 4);
        chk("w_jobs", 32'(jd[1]), 2);
        chk("w_finished_n", 32'(fin_n), 1);
        chk("w_error", 32'(err[1]), 0);
        chk("w_busy_after", 32'(bsy[1]), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/trigger_initiator.md
Name: trigger_initiator

Overview:
- Initiator side of the trigger/active/done job protocol: issues trigger pulses to a triggered responder FSM and tracks its active/done replies.
- Runs a batch of num_jobs jobs back-to-back: pulse, wait for active, wait for done, enforce an inter-job gap, repeat.
- Reports progress and completion, and flags responder timeouts.
- Sits between a control/sequencing layer (start/abort) and one responder instance.

Parameters:
PULSE_WIDTH, 1, cycles trigger is held high per job (>=1)
GAP_CYCLES, 2, cycles trigger is held low between done and the next pulse (>=1; guarantees a fresh rising edge at the responder)
TIMEOUT, 15, maximum cycles spent in each wait state before error (>=2)
CNT_W, 8, width of job count and completion counter

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  begin batch; sampled only in IDLE
num_jobs  in  CNT_W  jobs in batch; latched when start is accepted
abort  in  1  synchronous abort of a running batch
active_in  in  1  responder active status
done_in  in  1  responder done pulse
trigger  out  1  trigger to responder, registered
busy  out  1  high whenever state != IDLE
jobs_done  out  CNT_W  jobs completed in current/last batch
error  out  1  sticky timeout flag; cleared on next accepted start
finished  out  1  one-cycle pulse at batch end (normal, zero-length, timeout or abort)

Behaviour:
- Reset: state=IDLE; trigger=0, busy=0, jobs_done=0, error=0, finished=0; internal counters cleared. Reset overrides all inputs, including mid-batch.
- All outputs are registers; trigger and busy are decoded from the next state so they change on the same edge as the state.
- States: IDLE, PULSE, WAIT_ACTIVE, WAIT_DONE, GAP.
- IDLE, start=1, num_jobs!=0: latch target=num_jobs, jobs_done<=0, error<=0, go PULSE. trigger is high the cycle after start is sampled.
- IDLE, start=1, num_jobs==0: stay IDLE, jobs_done<=0, error<=0, finished=1 for one cycle.
- start outside IDLE is ignored.
- PULSE: trigger=1 for exactly PULSE_WIDTH cycles, then WAIT_ACTIVE with trigger=0.
- WAIT_ACTIVE: wait timer cleared on entry and incremented each cycle. active_in=1 -> WAIT_DONE. done_in=1 (responder skipped active) is also accepted and treated as in WAIT_DONE.
- WAIT_DONE: timer cleared on entry. done_in=1 -> jobs_done<=jobs_done+1. If the new value equals target, go IDLE with finished=1; otherwise go GAP.
- GAP: trigger=0 for exactly GAP_CYCLES cycles, then PULSE.
- Timeout: at most TIMEOUT cycles are spent in a wait state. If the expected event is absent in the TIMEOUT-th cycle, go IDLE with error<=1 and finished=1. jobs_done keeps its value.
- An event arriving in that same cycle wins over timeout.
- abort=1 in any non-IDLE state -> IDLE next cycle, trigger=0, finished=1. jobs_done holds; error is unchanged.
- abort has priority over done_in and timeout in the same cycle (the job is not counted).
- abort in IDLE has no effect. Simultaneous start+abort in IDLE: start is accepted.
- jobs_done never wraps within a batch: target <= 2^CNT_W-1.
- active_in/done_in are ignored in IDLE, PULSE and GAP.

Test Plan:
- Reset mid-batch (in WAIT_DONE, jobs_done=1): assert reset one cycle -> next cycle all outputs 0, state IDLE; later start works normally.
- Loopback to responder model (active one cycle after trigger rise, held 5 cycles, then 1-cycle done), defaults, num_jobs=3 -> 3 trigger rising edges, each 1 cycle wide and >=2 low cycles apart, jobs_done steps 1,2,3, one finished pulse, error=0, busy low after.
- start with num_jobs=0 -> finished=1 for one cycle the next cycle, trigger never rises, busy stays 0, jobs_done=0.
- Responder mute (active_in=0), TIMEOUT=15, num_jobs=2 -> exactly 15 cycles in WAIT_ACTIVE, then error=1, finished pulse, jobs_done=0; next start clears error.
- num_jobs=4, abort in the same cycle as the second done_in -> jobs_done=1, finished=1, trigger=0, busy=0 next cycle, error=0.
- PULSE_WIDTH=3, GAP_CYCLES=4, num_jobs=2 with loopback model -> trigger high 3 cycles per job, low exactly 4 cycles between done and next pulse; start asserted mid-batch is ignored.
